y_line_writer: RTL

- Write-side counterpart of the Y-vector address decoder in the SRAM integration path.
- Accepts per-row Y results (row index + 16-bit value) on a valid/ready stream and packs them into 256-bit Y SRAM lines of 16 lanes.
- Issues masked line writes at word address row>>4, the same mapping the read side uses for its row lookup.
- Flushes on line change, full line, or explicit flush request.

---
 rtl/y_line_writer_if.sv | 32 +++
 rtl/y_line_writer.sv | 104 ++++++++++
 2 files changed

// File: rtl/y_line_writer_if.sv
// Stream and SRAM-write bundle for y_line_writer.
// slave = writer side, master = producer/SRAM side.
interface y_line_writer_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 16
);
  logic                      yW_inValid;
  logic [ADDR_W-1:0]         yW_inRow;
  logic [DATA_W-1:0]         yW_inData;
  logic                      yW_inReady;
  logic                      yW_flush;
  logic                      yW_flushDone;
  logic                      yW_wrEn;
  logic [ADDR_W-1:0]         yW_wrAddr;
  logic [LANES*DATA_W-1:0]   yW_wrData;
  logic [LANES-1:0]          yW_wrMask;
  logic                      yW_wrReady;
  logic [15:0]               yW_linesWritten;

  modport slave (
    input  yW_inValid, yW_inRow, yW_inData, yW_flush, yW_wrReady,
    output yW_inReady, yW_flushDone, yW_wrEn, yW_wrAddr, yW_wrData,
    output yW_wrMask, yW_linesWritten
  );

  modport master (
    output yW_inValid, yW_inRow, yW_inData, yW_flush, yW_wrReady,
    input  yW_inReady, yW_flushDone, yW_wrEn, yW_wrAddr, yW_wrData,
    input  yW_wrMask, yW_linesWritten
  );
endinterface

// File: rtl/y_line_writer.sv
// Packs per-row Y results into masked SRAM line writes at address row>>log2(LANES).
// Define YW_ACCUM_EN to sum duplicate lanes instead of overwriting them.
module y_line_writer #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 16
) (
  input logic              clock,
  input logic              reset,
  y_line_writer_if.slave   bus
);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned TAG_W  = ADDR_W - LANE_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t            state, stateNext;
  logic [DATA_W-1:0] buffer [LANES];
  logic [LANES-1:0]  mask;
  logic [TAG_W-1:0]  tagReg;
  logic              flushPending;
  logic              flushDone;
  logic [15:0]       linesWritten;

  logic [TAG_W-1:0]  inTag;
  logic [LANE_W-1:0] inLane;
  logic              tagMatch;
  logic              inReady;
  logic              accept;
  logic [LANES-1:0]  maskNext;
  logic [DATA_W-1:0] laneValue;

  always_comb begin
    inTag    = bus.yW_inRow[ADDR_W-1:LANE_W];
    inLane   = bus.yW_inRow[LANE_W-1:0];
    tagMatch = (inTag == tagReg);
    inReady  = !reset && ((state == IDLE) || (state == FILL && tagMatch));
    accept   = bus.yW_inValid && inReady;
    maskNext = mask | (accept ? (LANES'(1) << inLane) : '0);
`ifdef YW_ACCUM_EN
    laneValue = mask[inLane] ? (buffer[inLane] + bus.yW_inData) : bus.yW_inData;
`else
    laneValue = bus.yW_inData;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (accept) stateNext = (bus.yW_flush || &maskNext) ? WRITE : FILL;
      FILL:  if ((accept && &maskNext) || bus.yW_flush ||
                 (bus.yW_inValid && !tagMatch)) stateNext = WRITE;
      WRITE: if (bus.yW_wrReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) buffer[i] <= '0;
      mask         <= '0;
      tagReg       <= '0;
      flushPending <= 1'b0;
      flushDone    <= 1'b0;
      linesWritten <= '0;
    end else begin
      flushDone <= 1'b0;
      if (accept) begin
        if (state == IDLE) tagReg <= inTag;
        buffer[inLane] <= laneValue;
        mask           <= maskNext;
      end
      // An empty IDLE flush completes at once; any other flush waits for the write.
      if (bus.yW_flush) begin
        if (state == IDLE && !accept) flushDone    <= 1'b1;
        else                          flushPending <= 1'b1;
      end
      if (state == WRITE && bus.yW_wrReady) begin
        mask <= '0;
        if (linesWritten != '1) linesWritten <= linesWritten + 16'd1;
        if (flushPending || bus.yW_flush) begin
          flushDone    <= 1'b1;
          flushPending <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.yW_inReady      = inReady;
    bus.yW_flushDone    = flushDone;
    bus.yW_linesWritten = linesWritten;
    bus.yW_wrEn         = (state == WRITE);
    bus.yW_wrAddr       = (state == WRITE) ? ADDR_W'(tagReg) : '0;
    bus.yW_wrMask       = (state == WRITE) ? mask : '0;
    for (int unsigned i = 0; i < LANES; i++)
      bus.yW_wrData[i*DATA_W +: DATA_W] = (state == WRITE && mask[i]) ? buffer[i] : '0;
  end
endmodule
